// File: rtl/regwb_decode_scoreboard_pkg.sv
// Shared constants for the writeback decode / pending-write scoreboard slice.
package regwb_decode_scoreboard_pkg;

    localparam int unsigned ADDR_W_DEF = 4;
    // Architectural zero register index
    localparam int unsigned ZERO_REG   = 0;

    function automatic int unsigned nreg_of(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/regwb_decode_scoreboard_if.sv
// Issue / writeback / operand-check bundle between the pipeline and the scoreboard.
interface regwb_decode_scoreboard_if
    import regwb_decode_scoreboard_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned CNT_W  = ADDR_W + 1
) ();

    localparam int unsigned NREG = nreg_of(ADDR_W);

    logic              issue_valid;
    logic [ADDR_W-1:0] issue_addr;
    logic              issue_ready;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [NREG-1:0]   wen_onehot;
    logic [NREG-1:0]   pending;
    logic [CNT_W-1:0]  pend_cnt;
    logic [ADDR_W-1:0] src_a_addr;
    logic [ADDR_W-1:0] src_b_addr;
    logic              hazard_a;
    logic              hazard_b;
    logic              err_wb_idle;

    modport master (
        output issue_valid, issue_addr, wb_valid, wb_addr, src_a_addr, src_b_addr,
        input  issue_ready, wen_onehot, pending, pend_cnt, hazard_a, hazard_b, err_wb_idle
    );

    modport slave (
        input  issue_valid, issue_addr, wb_valid, wb_addr, src_a_addr, src_b_addr,
        output issue_ready, wen_onehot, pending, pend_cnt, hazard_a, hazard_b, err_wb_idle
    );

endinterface

// File: rtl/regwb_decode_scoreboard_onehot_decode.sv
// Parametrised ADDR_W -> 2**ADDR_W one-hot decoder with enable and optional zero-register mask.
module onehot_decode
    import regwb_decode_scoreboard_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter bit          ZERO_MASK = 1'b1
) (
    input  logic                        en,
    input  logic [ADDR_W-1:0]           addr,
    output logic [nreg_of(ADDR_W)-1:0]  onehot
);

    logic masked;

    assign masked = ZERO_MASK && (addr == ADDR_W'(ZERO_REG));

    // Single bit set for the enabled, unmasked address
    always_comb begin
        onehot = '0;
        if (en && !masked) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/regwb_decode_scoreboard.sv
// Writeback one-hot decode plus pending-write scoreboard with WAW stall and RAW hazard flags.
module regwb_decode_scoreboard
    import regwb_decode_scoreboard_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter bit          ZERO_REG_RO = 1'b1,
    parameter int unsigned CNT_W       = ADDR_W + 1
) (
    input  logic                       clk,
    input  logic                       reset,
    regwb_decode_scoreboard_if.slave   bus
);

    localparam int unsigned NREG = nreg_of(ADDR_W);

    logic [NREG-1:0]  pending_q, pending_d;
    logic [NREG-1:0]  wen_q;
    logic [NREG-1:0]  set_vec, clr_vec;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             issue_ready, accept, zero_issue, inc, dec;

    assign zero_issue = ZERO_REG_RO && (bus.issue_addr == ADDR_W'(ZERO_REG));

    // WAW stall: a same-cycle writeback to the destination frees it
    assign issue_ready = zero_issue || !pending_q[bus.issue_addr] ||
                         (bus.wb_valid && (bus.wb_addr == bus.issue_addr));
    assign accept      = bus.issue_valid && issue_ready;

    onehot_decode #(
        .ADDR_W    (ADDR_W),
        .ZERO_MASK (ZERO_REG_RO)
    ) u_set_dec (
        .en     (accept),
        .addr   (bus.issue_addr),
        .onehot (set_vec)
    );

    onehot_decode #(
        .ADDR_W    (ADDR_W),
        .ZERO_MASK (ZERO_REG_RO)
    ) u_clr_dec (
        .en     (bus.wb_valid),
        .addr   (bus.wb_addr),
        .onehot (clr_vec)
    );

    // Scoreboard next state; set wins over clear, counter follows the popcount change
    always_comb begin
        pending_d = (pending_q & ~clr_vec) | set_vec;
        inc       = |(set_vec & ~pending_q);
        dec       = |(clr_vec & pending_q & ~set_vec);
        cnt_d     = cnt_q + CNT_W'(inc) - CNT_W'(dec);
        err_d     = err_q | (|(clr_vec & ~pending_q));
    end

    // State update with synchronous reset priority
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
            wen_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            wen_q     <= clr_vec;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    assign bus.issue_ready = issue_ready;
    assign bus.wen_onehot  = wen_q;
    assign bus.pending     = pending_q;
    assign bus.pend_cnt    = cnt_q;
    assign bus.err_wb_idle = err_q;
    // Writeback data is forwarded, so a same-cycle writeback hides the hazard
    assign bus.hazard_a    = pending_q[bus.src_a_addr] &&
                             !(bus.wb_valid && (bus.wb_addr == bus.src_a_addr));
    assign bus.hazard_b    = pending_q[bus.src_b_addr] &&
                             !(bus.wb_valid && (bus.wb_addr == bus.src_b_addr));

endmodule

// File: tb/tb_regwb_decode_scoreboard.sv
// Scoreboard bench: ADDR_W=4 and ADDR_W=5 instances driven together, checked against a reference model.
module tb_regwb_decode_scoreboard;

    logic clk;
    logic reset;

    regwb_decode_scoreboard_if #(.ADDR_W(4)) if4 ();
    regwb_decode_scoreboard_if #(.ADDR_W(5)) if5 ();

    regwb_decode_scoreboard #(.ADDR_W(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));
    regwb_decode_scoreboard #(.ADDR_W(5)) dut5 (.clk(clk), .reset(reset), .bus(if5));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          dut;
        bit          chk;
        logic [31:0] pend;
        logic [31:0] wen;
        int          cnt;
        bit          err;
        bit          rdy;
        bit          ha;
        bit          hb;
    } rec_t;

    rec_t exp_q[$];

    int total = 0;
    int bad   = 0;

    // Reference model: a bit per register, plain popcount for the counter
    logic [31:0] m_pend[2];
    logic [31:0] m_wen[2];
    bit          m_err[2];
    bit          m_known[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_cycle(input int d, input int aw, input bit rst, input bit iv, input int ia_in,
                               input bit wv, input int wa_in, input int sa_in, input int sb_in);
        rec_t r;
        int   m, ia, wa, sa, sb;
        m  = (1 << aw) - 1;
        ia = ia_in & m;
        wa = wa_in & m;
        sa = sa_in & m;
        sb = sb_in & m;
        r.dut  = d;
        r.chk  = m_known[d];
        r.pend = m_pend[d];
        r.wen  = m_wen[d];
        r.cnt  = $countones(m_pend[d]);
        r.err  = m_err[d];
        r.rdy  = (ia == 0) || !m_pend[d][ia] || (wv && wa == ia);
        r.ha   = m_pend[d][sa] && !(wv && wa == sa);
        r.hb   = m_pend[d][sb] && !(wv && wa == sb);
        exp_q.push_back(r);
        if (rst) begin
            m_pend[d]  = '0;
            m_wen[d]   = '0;
            m_err[d]   = 1'b0;
            m_known[d] = 1'b1;
        end else begin
            m_wen[d] = (wv && wa != 0) ? (32'd1 << wa) : 32'd0;
            if (wv && wa != 0 && !m_pend[d][wa]) m_err[d] = 1'b1;
            if (wv) m_pend[d][wa] = 1'b0;
            if (iv && r.rdy && ia != 0) m_pend[d][ia] = 1'b1;
        end
    endtask

    // Drive one cycle on both instances (entered and left at posedge + 1)
    task automatic cyc(input bit rst, input bit iv, input int ia, input bit wv, input int wa,
                       input int sa, input int sb);
        reset           = rst;
        if4.issue_valid = iv;
        if4.issue_addr  = 4'(ia);
        if4.wb_valid    = wv;
        if4.wb_addr     = 4'(wa);
        if4.src_a_addr  = 4'(sa);
        if4.src_b_addr  = 4'(sb);
        if5.issue_valid = iv;
        if5.issue_addr  = 5'(ia);
        if5.wb_valid    = wv;
        if5.wb_addr     = 5'(wa);
        if5.src_a_addr  = 5'(sa);
        if5.src_b_addr  = 5'(sb);
        model_cycle(0, 4, rst, iv, ia, wv, wa, sa, sb);
        model_cycle(1, 5, rst, iv, ia, wv, wa, sa, sb);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int sa);
        cyc(1'b0, 1'b0, 0, 1'b0, 0, sa, 0);
    endtask

    // Monitor: compare everything the DUTs present this cycle against queued expectations
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            rec_t        r;
            logic [31:0] a_pend, a_wen, a_cnt;
            logic        a_err, a_rdy, a_ha, a_hb;
            string       tag;
            r = exp_q.pop_front();
            if (r.dut == 0) begin
                a_pend = 32'(if4.pending);
                a_wen  = 32'(if4.wen_onehot);
                a_cnt  = 32'(if4.pend_cnt);
                a_err  = if4.err_wb_idle;
                a_rdy  = if4.issue_ready;
                a_ha   = if4.hazard_a;
                a_hb   = if4.hazard_b;
                tag    = "aw4";
            end else begin
                a_pend = 32'(if5.pending);
                a_wen  = 32'(if5.wen_onehot);
                a_cnt  = 32'(if5.pend_cnt);
                a_err  = if5.err_wb_idle;
                a_rdy  = if5.issue_ready;
                a_ha   = if5.hazard_a;
                a_hb   = if5.hazard_b;
                tag    = "aw5";
            end
            if (r.chk) begin
                check({tag, " pending"},     a_pend,       r.pend);
                check({tag, " wen_onehot"},  a_wen,        r.wen);
                check({tag, " pend_cnt"},    a_cnt,        32'(r.cnt));
                check({tag, " err_wb_idle"}, 32'(a_err),   32'(r.err));
                check({tag, " issue_ready"}, 32'(a_rdy),   32'(r.rdy));
                check({tag, " hazard_a"},    32'(a_ha),    32'(r.ha));
                check({tag, " hazard_b"},    32'(a_hb),    32'(r.hb));
            end
        end
    end

    initial begin
        m_pend  = '{default: '0};
        m_wen   = '{default: '0};
        m_err   = '{default: 1'b0};
        m_known = '{default: 1'b0};
        reset   = 1'b1;
        if4.issue_valid = 1'b0; if4.issue_addr = '0; if4.wb_valid = 1'b0; if4.wb_addr = '0;
        if4.src_a_addr  = '0;   if4.src_b_addr = '0;
        if5.issue_valid = 1'b0; if5.issue_addr = '0; if5.wb_valid = 1'b0; if5.wb_addr = '0;
        if5.src_a_addr  = '0;   if5.src_b_addr = '0;
        @(posedge clk);
        #1;

        // Reset held two cycles with a competing issue
        cyc(1'b1, 1'b1, 5, 1'b0, 0, 5, 0);
        cyc(1'b1, 1'b1, 5, 1'b0, 0, 5, 0);
        idle(0);
        check("t1 pending", 32'(if4.pending), 32'h0);
        check("t1 pend_cnt", 32'(if4.pend_cnt), 32'h0);
        check("t1 wen_onehot", 32'(if4.wen_onehot), 32'h0);

        // Issue 3, hold, writeback 3
        cyc(1'b0, 1'b1, 3, 1'b0, 0, 3, 3);
        check("t2 pending", 32'(if4.pending), 32'h0008);
        check("t2 pend_cnt", 32'(if4.pend_cnt), 32'd1);
        idle(3);
        idle(3);
        cyc(1'b0, 1'b0, 0, 1'b1, 3, 3, 0);
        check("t2 wen_onehot", 32'(if4.wen_onehot), 32'h0008);
        check("t2 pending clr", 32'(if4.pending), 32'h0);
        check("t2 pend_cnt clr", 32'(if4.pend_cnt), 32'd0);

        // WAW stall on 7, then release by same-cycle writeback
        cyc(1'b0, 1'b1, 7, 1'b0, 0, 7, 0);
        cyc(1'b0, 1'b1, 7, 1'b0, 0, 7, 0);
        check("t3 stall pending", 32'(if4.pending), 32'h0080);
        check("t3 stall pend_cnt", 32'(if4.pend_cnt), 32'd1);
        cyc(1'b0, 1'b1, 7, 1'b1, 7, 7, 0);
        check("t3 reissue pending", 32'(if4.pending), 32'h0080);
        check("t3 reissue pend_cnt", 32'(if4.pend_cnt), 32'd1);
        check("t3 reissue wen", 32'(if4.wen_onehot), 32'h0080);
        cyc(1'b0, 1'b0, 0, 1'b1, 7, 0, 7);

        // Zero register is never tracked
        cyc(1'b0, 1'b1, 0, 1'b0, 0, 0, 0);
        check("t4 pending", 32'(if4.pending), 32'h0);
        cyc(1'b0, 1'b0, 0, 1'b1, 0, 0, 0);
        check("t4 wen_onehot", 32'(if4.wen_onehot), 32'h0);
        check("t4 err", 32'(if4.err_wb_idle), 32'h0);

        // Idle writeback error is sticky; fill all writable registers
        cyc(1'b0, 1'b0, 0, 1'b1, 9, 9, 0);
        check("t5 wen_onehot", 32'(if4.wen_onehot), 32'h0200);
        check("t5 err", 32'(if4.err_wb_idle), 32'h1);
        cyc(1'b0, 1'b1, 2, 1'b0, 0, 2, 0);
        cyc(1'b0, 1'b0, 0, 1'b1, 2, 2, 0);
        check("t5 err sticky", 32'(if4.err_wb_idle), 32'h1);
        for (int a = 1; a < 16; a++) cyc(1'b0, 1'b1, a, 1'b0, 0, a, 0);
        check("t5 fill pend_cnt", 32'(if4.pend_cnt), 32'd15);
        check("t5 fill pending", 32'(if4.pending), 32'hfffe);
        cyc(1'b0, 1'b1, 1, 1'b0, 0, 1, 15);
        check("t5 full pend_cnt", 32'(if4.pend_cnt), 32'd15);
        cyc(1'b1, 1'b0, 0, 1'b0, 0, 0, 0);
        check("t5 reset pend_cnt", 32'(if4.pend_cnt), 32'd0);
        check("t5 reset err", 32'(if4.err_wb_idle), 32'h0);

        // Random issue/writeback streams
        for (int i = 0; i < 3000; i++) begin
            bit rst;
            rst = ($urandom_range(0, 399) == 0);
            cyc(rst, 1'($urandom), int'($urandom_range(0, 31)), 1'($urandom_range(0, 2) != 0),
                int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                int'($urandom_range(0, 31)));
        end

        idle(0);
        @(negedge clk);
        #1;
        check("queue drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
